// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit a + b + cin, one bit per clock, LSB first,
// through a single full-adder cell with a registered carry.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);
   assign sum       = a ^ b ^ carry_in;
   assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shift_a, shift_b, partial;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_cout;
   logic             last_bit, accept;

   full_adder u_fa (
      .a         (shift_a[0]),
      .b         (shift_b[0]),
      .carry_in  (carry),
      .sum       (fa_sum),
      .carry_out (fa_cout)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));
   // New operands are only taken when no operation is in flight.
   assign accept   = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         shift_a <= '0;
         shift_b <= '0;
         partial <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= cin;
            cnt     <= '0;
            partial <= '0;
         end else if (state == RUN) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            carry   <= fa_cout;
            partial <= {fa_sum, partial[WIDTH-1:1]};
            if (last_bit) begin
               sum  <= {fa_sum, partial[WIDTH-1:1]};
               cout <= fa_cout;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance for timing/function,
// WIDTH=2 instance for an exhaustive sweep.

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic       start2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       cin2 = 1'b0;
   logic       busy2, done2, cout2;
   logic [1:0] sum2;

   int checks = 0;
   int failures = 0;
   logic [8:0] exp_q[$];
   logic [2:0] exp2_q[$];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] pop8();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   function automatic logic [2:0] pop2();
      if (exp2_q.size() == 0) return 'x;
      return exp2_q.pop_front();
   endfunction

   // One isolated WIDTH=8 operation with full latency/busy checking.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
      exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
      @(negedge clk);
      start8 = 1'b0; a8 = $urandom_range(0, 255); b8 = $urandom_range(0, 255);
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_busy_phase"}, {busy8, done8}, 2'b10);
         @(negedge clk);
      end
      chk({tag, "_done_phase"}, {busy8, done8}, 2'b01);
      chk({tag, "_result"}, {cout8, sum8}, pop8());
      @(negedge clk);
      chk({tag, "_after"}, {busy8, done8}, 2'b00);
   endtask

   task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
      int lat;
      @(negedge clk);
      start2 = 1'b1; a2 = a; b2 = b; cin2 = c;
      exp2_q.push_back({1'b0, a} + {1'b0, b} + {2'd0, c});
      lat = 0;
      do begin
         @(negedge clk);
         start2 = 1'b0;
         lat++;
      end while (!done2 && lat < 10);
      chk("w2_latency", lat, 3);
      chk("w2_result", {cout2, sum2}, pop2());
   endtask

   initial begin
      int ndone, cyc;
      // Reset and idle.
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_after_reset", {busy8, done8, cout8, sum8}, 11'd0);
      end

      op8(8'h3C, 8'h5A, 1'b0, "add_3c_5a");
      op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
      op8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");

      // A start during RUN must be ignored.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
      exp_q.push_back(9'h002);
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      @(negedge clk);
      start8 = 1'b0;
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         if (done8) begin
            ndone++;
            chk("ignored_start_result", {cout8, sum8}, pop8());
         end
         @(negedge clk);
      end
      chk("ignored_start_done_count", ndone, 1);

      // Reset mid-RUN aborts.
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_state", {busy8, done8, cout8, sum8}, 11'd0);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      chk("abort_no_done", ndone, 0);

      // Back-to-back with start held high.
      start8 = 1'b1;
      a8 = $urandom_range(0, 255); b8 = $urandom_range(0, 255); cin8 = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
      for (int r = 0; r < 5; r++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
            if (!done8) begin
               a8 = $urandom_range(0, 255); b8 = $urandom_range(0, 255);
               cin8 = 1'($urandom_range(0, 1));
            end
         end while (!done8 && cyc < 20);
         chk("b2b_interval", cyc, 9);
         chk("b2b_result", {cout8, sum8}, pop8());
         if (r < 4) begin
            a8 = $urandom_range(0, 255); b8 = $urandom_range(0, 255);
            cin8 = 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
         end else begin
            start8 = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b_stop", {busy8, done8}, 2'b00);

      // WIDTH=2 exhaustive sweep.
      for (int v = 0; v < 32; v++) begin
         logic [4:0] vv;
         vv = 5'(v);
         op2(vv[4:3], vv[2:1], vv[0]);
      end

      chk("sb_empty", exp_q.size() + exp2_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
